// File: rtl/mem_responder_pkg.sv
// Shared types for the wait-state memory responder: scalar widths and the FSM state enum.
package mem_responder_pkg;

  typedef logic        u1;
  typedef logic [3:0]  u4;
  typedef logic [31:0] u32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } mem_state_t;

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous word RAM with a registered read port; contents are never reset.
module mem_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256
) (
  input  logic                           clk,
  input  logic                           i_en,
  input  logic                           i_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] i_addr,
  input  logic [31:0]                    i_wdata,
  output logic [31:0]                    o_rdata
);

  u32 r_mem [DEPTH_WORDS];
  u32 r_rdata;

  // Read data lands one edge after an enabled read and holds until the next one.
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wdata;
      end else begin
        r_rdata <= r_mem[i_addr];
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one request at a time, inserts WAIT_CYCLES wait states, then responds.
// Optional MEM_ALIGN_CHECK_EN: misaligned requests skip the array and return resp_err=1.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW        = $clog2(DEPTH_WORDS);
  localparam u4  WAIT_LOAD = (WAIT_CYCLES > 0) ? u4'(WAIT_CYCLES - 1) : u4'(0);

  mem_state_t r_state;
  mem_state_t w_next;
  u4          r_cnt;
  u1          r_write;
  u32         r_addr;
  u32         r_wdata;
  u32         w_rdata;
  u1          w_accept;
  u1          w_misal;
  u1          w_err;
  u1          w_unused;

  assign w_accept = req_valid && (r_state == IDLE);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misal = (req_addr[1:0] != 2'b00);
  assign w_err   = (r_addr[1:0] != 2'b00);
`else
  assign w_misal = 1'b0;
  assign w_err   = 1'b0;
`endif

  // Address bits outside the word index only matter for the optional alignment check.
  assign w_unused = ^{r_addr[31:AW+2], r_addr[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_cnt   <= WAIT_LOAD;
      r_write <= req_write;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end else if ((r_state == WAIT) && (r_cnt != '0)) begin
      r_cnt <= r_cnt - u4'(1);
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (req_valid) begin
          if (w_misal) begin
            w_next = RESP;
          end else if (WAIT_CYCLES > 0) begin
            w_next = WAIT;
          end else begin
            w_next = ACCESS;
          end
        end
      end
      WAIT:    if (r_cnt == '0) w_next = ACCESS;
      ACCESS:  w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  mem_array #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_mem_array (
    .clk     (clk),
    .i_en    (r_state == ACCESS),
    .i_we    (r_write),
    .i_addr  (r_addr[AW+1:2]),
    .i_wdata (r_wdata),
    .o_rdata (w_rdata)
  );

  assign req_ready  = (r_state == IDLE);
  assign resp_valid = (r_state == RESP);
  assign resp_err   = resp_valid && w_err;
  assign resp_rdata = (resp_valid && !r_write && !w_err) ? w_rdata : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: one instance with WAIT_CYCLES=2, one with WAIT_CYCLES=0.
// Honours MEM_ALIGN_CHECK_EN when the bench is built with it.
module tb_mem_responder;

  typedef struct {
    int          d;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    bit          hold;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reqValid [2];
  logic        reqWrite [2];
  logic [31:0] reqAddr  [2];
  logic [31:0] reqWdata [2];
  logic        reqReady [2];
  logic        respValid[2];
  logic [31:0] respRdata[2];
  logic        respErr  [2];

  int   testsRun = 0;
  int   testsFailed = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dutWait2 (
    .clk(clk), .reset(reset),
    .req_valid(reqValid[0]), .req_write(reqWrite[0]), .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]),
    .req_ready(reqReady[0]), .resp_valid(respValid[0]), .resp_rdata(respRdata[0]), .resp_err(respErr[0])
  );

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dutWait0 (
    .clk(clk), .reset(reset),
    .req_valid(reqValid[1]), .req_write(reqWrite[1]), .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]),
    .req_ready(reqReady[1]), .resp_valid(respValid[1]), .resp_rdata(respRdata[1]), .resp_err(respErr[1])
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    for (int d = 0; d < 2; d++) begin
      checkOutput({tag, "_ready"}, 32'(reqReady[d]), 32'd1);
      checkOutput({tag, "_valid"}, 32'(respValid[d]), 32'd0);
      checkOutput({tag, "_rdata"}, respRdata[d], 32'd0);
      checkOutput({tag, "_err"}, 32'(respErr[d]), 32'd0);
    end
  endtask

  // One complete transaction on instance d; the expected response is queued at acceptance.
  task automatic applyStimulus(input int d, input bit wr, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [31:0] expRdata, input bit hold);
    exp_t e;
    exp_t got;
    bit   misal;
    bit   seen;
`ifdef MEM_ALIGN_CHECK_EN
    misal = (addr[1:0] != 2'b00);
`else
    misal = 1'b0;
`endif
    e.err   = misal;
    e.rdata = (wr || misal) ? 32'd0 : expRdata;
    e.lat   = misal ? 0 : ((d == 0) ? 2 : 0) + 1;

    @(negedge clk);
    checkOutput("ready_idle", 32'(reqReady[d]), 32'd1);
    reqValid[d] = 1'b1;
    reqWrite[d] = wr;
    reqAddr[d]  = addr;
    reqWdata[d] = wdata;
    @(posedge clk);
    sb.push_back(e);

    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (respValid[d]) begin
        got = sb.pop_front();
        checkOutput("resp_rdata", respRdata[d], got.rdata);
        checkOutput("resp_err", 32'(respErr[d]), 32'(got.err));
        checkOutput("resp_latency", 32'(n), 32'(got.lat));
        checkOutput("ready_resp", 32'(reqReady[d]), 32'd0);
        reqValid[d] = 1'b0;
        seen = 1'b1;
      end else begin
        checkOutput("ready_busy", 32'(reqReady[d]), 32'd0);
        checkOutput("rdata_busy", respRdata[d], 32'd0);
        if (hold) begin
          reqWrite[d] = 1'($urandom_range(0, 1));
          reqAddr[d]  = $urandom;
          reqWdata[d] = $urandom;
        end else begin
          reqValid[d] = 1'b0;
        end
      end
    end
    if (!seen) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL resp_timeout: got no resp_valid, expected one within 20 cycles");
      reqValid[d] = 1'b0;
      sb.delete();
    end
  endtask

  vec_t        vecs[$];
  logic [31:0] prior;

  initial begin
    for (int d = 0; d < 2; d++) begin
      reqValid[d] = 1'b0;
      reqWrite[d] = 1'b0;
      reqAddr[d]  = '0;
      reqWdata[d] = '0;
    end

    vecs.push_back('{0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0});
    vecs.push_back('{0, 1'b0, 32'h0000_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1, 1'b1, 32'h0000_0404, 32'h1234_5678, 32'h0, 1'b0});
    vecs.push_back('{1, 1'b0, 32'h0000_0004, 32'h0,         32'h1234_5678, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0, 1'b0});
    vecs.push_back('{0, 1'b0, 32'hFFFF_FFFC, 32'h0,         32'hCAFE_F00D, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h0000_0000, 32'h0000_0001, 32'h0, 1'b0});
    vecs.push_back('{0, 1'b0, 32'h0000_0400, 32'h0,         32'h0000_0001, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h0000_0044, 32'h5A5A_5A5A, 32'h0, 1'b1});
    vecs.push_back('{0, 1'b0, 32'h0000_0044, 32'h0,         32'h5A5A_5A5A, 1'b1});
    vecs.push_back('{1, 1'b1, 32'h0000_0008, 32'hFFFF_FFFF, 32'h0, 1'b1});
    vecs.push_back('{1, 1'b0, 32'h0000_0008, 32'h0,         32'hFFFF_FFFF, 1'b0});
    vecs.push_back('{0, 1'b1, 32'h0000_0020, 32'h0BAD_CAFE, 32'h0, 1'b0});

    // Reset held for three cycles, then released; idle outputs must hold throughout.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkIdleOutputs("reset_hold");
    end
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checkIdleOutputs("post_reset");
    end

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].d, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].expRdata, vecs[i].hold);
    end

    // Misaligned write to 0x22: rejected with the alignment check, stored to word 0x20 without it.
    applyStimulus(0, 1'b1, 32'h0000_0022, 32'h7777_8888, 32'h0, 1'b0);
`ifdef MEM_ALIGN_CHECK_EN
    prior = 32'h0BAD_CAFE;
`else
    prior = 32'h7777_8888;
`endif
    applyStimulus(0, 1'b0, 32'h0000_0020, 32'h0, prior, 1'b0);

    // Reset pulsed during WAIT of a write must abort it without touching the array.
    @(negedge clk);
    reqValid[0] = 1'b1;
    reqWrite[0] = 1'b1;
    reqAddr[0]  = 32'h0000_0020;
    reqWdata[0] = 32'hAAAA_5555;
    @(posedge clk);
    @(negedge clk);
    reqValid[0] = 1'b0;
    checkOutput("abort_in_wait", 32'(reqReady[0]), 32'd0);
    reset = 1'b1;
    #1;
    checkOutput("abort_async_ready", 32'(reqReady[0]), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checkOutput("abort_no_resp", 32'(respValid[0]), 32'd0);
    end
    applyStimulus(0, 1'b0, 32'h0000_0020, 32'h0, prior, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
